// File: rtl/mod_exp.sv
// RSA modular exponentiation engine: result = c^EXPONENT mod MODULUS.
// Bit-serial interleaved modular multiply driving left-to-right square-and-multiply.
module mod_exp #(
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned NUM_WORDS  = 32,
    parameter logic [DATA_WIDTH*NUM_WORDS-1:0] MODULUS  = {(DATA_WIDTH*NUM_WORDS){1'b1}},
    parameter logic [DATA_WIDTH*NUM_WORDS-1:0] EXPONENT = (DATA_WIDTH*NUM_WORDS)'(65537)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  startInput,
    input  logic                  startCompute,
    input  logic                  getResult,
    input  logic [DATA_WIDTH-1:0] inp,
    output logic [4:0]            stateModExp,
    output logic [2:0]            stateModExpSub,
    output logic [DATA_WIDTH-1:0] outp
);

    localparam int unsigned K  = DATA_WIDTH * NUM_WORDS;
    localparam int unsigned KW = (K > 1) ? $clog2(K) : 1;
    localparam int unsigned CW = $clog2(NUM_WORDS + 1);
    localparam logic [K+1:0] N_EXT = {2'b00, MODULUS};

    typedef enum logic [4:0] {
        ST_IDLE    = 5'd0,
        ST_LOAD    = 5'd1,
        ST_WAIT    = 5'd2,
        ST_COMPUTE = 5'd3,
        ST_DONE    = 5'd4,
        ST_OUTPUT  = 5'd5
    } state_t;

    typedef enum logic [2:0] {
        SUB_IDLE    = 3'd0,
        SUB_REDUCE  = 3'd1,
        SUB_SQUARE  = 3'd2,
        SUB_MULT    = 3'd3,
        SUB_NEXTBIT = 3'd4
    } sub_t;

    state_t                state_q;
    sub_t                  sub_q;
    logic [DATA_WIDTH-1:0] outp_q;
    logic [CW-1:0]         cnt_q;
    logic [K-1:0]          c_q;
    logic [K-1:0]          cr_q;
    logic [K-1:0]          r_q;
    logic [K-1:0]          acc_q;
    logic [KW-1:0]         j_q;
    logic [KW-1:0]         i_q;

    logic [K-1:0] mm_a;
    logic [K-1:0] mm_b;
    logic [K+1:0] t_sum;
    logic [K+1:0] t_red1;
    logic [K-1:0] mm_next;

    // One interleaved multiply step: acc = (2*acc + B[j]*A) mod N, with acc, A < N.
    always_comb begin
        mm_a = r_q;
        mm_b = r_q;
        if (sub_q == SUB_REDUCE) begin
            mm_a = K'(1);
            mm_b = c_q;
        end else if (sub_q == SUB_MULT) begin
            mm_b = cr_q;
        end
        t_sum   = {1'b0, acc_q, 1'b0} + (mm_b[j_q] ? {2'b00, mm_a} : '0);
        t_red1  = (t_sum >= N_EXT) ? (t_sum - N_EXT) : t_sum;
        mm_next = K'((t_red1 >= N_EXT) ? (t_red1 - N_EXT) : t_red1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            sub_q   <= SUB_IDLE;
            outp_q  <= '0;
            cnt_q   <= '0;
            c_q     <= '0;
            cr_q    <= '0;
            r_q     <= '0;
            acc_q   <= '0;
            j_q     <= '0;
            i_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (startInput) begin
                        state_q <= ST_LOAD;
                        cnt_q   <= '0;
                        r_q     <= '0;
                    end
                end
                ST_LOAD: begin
                    c_q[int'(cnt_q)*DATA_WIDTH +: DATA_WIDTH] <= inp;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(NUM_WORDS - 1)) begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (startCompute) begin
                        state_q <= ST_COMPUTE;
                        sub_q   <= SUB_REDUCE;
                        acc_q   <= '0;
                        j_q     <= KW'(K - 1);
                    end
                end
                ST_COMPUTE: begin
                    case (sub_q)
                        SUB_REDUCE: begin
                            if (j_q == '0) begin
                                cr_q  <= mm_next;
                                r_q   <= K'(1);
                                i_q   <= KW'(K - 1);
                                sub_q <= SUB_SQUARE;
                                acc_q <= '0;
                                j_q   <= KW'(K - 1);
                            end else begin
                                acc_q <= mm_next;
                                j_q   <= j_q - KW'(1);
                            end
                        end
                        SUB_SQUARE: begin
                            if (j_q == '0) begin
                                r_q <= mm_next;
                                if (EXPONENT[i_q]) begin
                                    sub_q <= SUB_MULT;
                                    acc_q <= '0;
                                    j_q   <= KW'(K - 1);
                                end else begin
                                    sub_q <= SUB_NEXTBIT;
                                end
                            end else begin
                                acc_q <= mm_next;
                                j_q   <= j_q - KW'(1);
                            end
                        end
                        SUB_MULT: begin
                            if (j_q == '0) begin
                                r_q   <= mm_next;
                                sub_q <= SUB_NEXTBIT;
                            end else begin
                                acc_q <= mm_next;
                                j_q   <= j_q - KW'(1);
                            end
                        end
                        SUB_NEXTBIT: begin
                            if (i_q == '0) begin
                                state_q <= ST_DONE;
                                sub_q   <= SUB_IDLE;
                            end else begin
                                i_q   <= i_q - KW'(1);
                                sub_q <= SUB_SQUARE;
                                acc_q <= '0;
                                j_q   <= KW'(K - 1);
                            end
                        end
                        default: begin
                            state_q <= ST_IDLE;
                            sub_q   <= SUB_IDLE;
                        end
                    endcase
                end
                ST_DONE: begin
                    if (getResult) begin
                        state_q <= ST_OUTPUT;
                        outp_q  <= r_q[DATA_WIDTH-1:0];
                        cnt_q   <= CW'(1);
                    end
                end
                ST_OUTPUT: begin
                    // Last word has been on outp for one cycle: drop back to idle.
                    if (cnt_q == CW'(NUM_WORDS)) begin
                        state_q <= ST_IDLE;
                        outp_q  <= '0;
                        cnt_q   <= '0;
                    end else begin
                        outp_q <= r_q[int'(cnt_q)*DATA_WIDTH +: DATA_WIDTH];
                        cnt_q  <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    sub_q   <= SUB_IDLE;
                    outp_q  <= '0;
                end
            endcase
        end
    end

    assign stateModExp    = state_q;
    assign stateModExpSub = sub_q;
    assign outp           = outp_q;

endmodule

// File: tb/tb_mod_exp.sv
// Bench for mod_exp: three small-key instances (E=17, 2753, 0) share stimulus;
// expected results come from an integer square-and-multiply reference queued per job.
module tb_mod_exp;

    localparam int unsigned DW = 8;
    localparam int unsigned NW = 2;
    localparam int unsigned KB = DW * NW;
    localparam logic [15:0] N   = 16'd3233;
    localparam logic [15:0] E_A = 16'd17;
    localparam logic [15:0] E_B = 16'd2753;
    localparam logic [15:0] E_C = 16'd0;
    localparam int unsigned DONE_BOUND = 2000;

    typedef logic [2:0][15:0] exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          startInput;
    logic          startCompute;
    logic          getResult;
    logic [DW-1:0] inp;
    logic [4:0]    st   [3];
    logic [2:0]    sub  [3];
    logic [DW-1:0] outp [3];

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    mod_exp #(.DATA_WIDTH(DW), .NUM_WORDS(NW), .MODULUS(N), .EXPONENT(E_A)) u_e17 (
        .clk(clk), .reset(reset), .startInput(startInput), .startCompute(startCompute),
        .getResult(getResult), .inp(inp), .stateModExp(st[0]), .stateModExpSub(sub[0]),
        .outp(outp[0]));
    mod_exp #(.DATA_WIDTH(DW), .NUM_WORDS(NW), .MODULUS(N), .EXPONENT(E_B)) u_e2753 (
        .clk(clk), .reset(reset), .startInput(startInput), .startCompute(startCompute),
        .getResult(getResult), .inp(inp), .stateModExp(st[1]), .stateModExpSub(sub[1]),
        .outp(outp[1]));
    mod_exp #(.DATA_WIDTH(DW), .NUM_WORDS(NW), .MODULUS(N), .EXPONENT(E_C)) u_e0 (
        .clk(clk), .reset(reset), .startInput(startInput), .startCompute(startCompute),
        .getResult(getResult), .inp(inp), .stateModExp(st[2]), .stateModExpSub(sub[2]),
        .outp(outp[2]));

    function automatic logic [15:0] ref_modexp(input logic [15:0] c, input logic [15:0] e);
        longint unsigned r;
        longint unsigned b;
        r = 1;
        b = longint'(c) % longint'(N);
        for (int i = 15; i >= 0; i--) begin
            r = (r * r) % longint'(N);
            if (e[i]) r = (r * b) % longint'(N);
        end
        return 16'(r);
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_expect(input logic [15:0] c);
        exp_t e;
        e[0] = ref_modexp(c, E_A);
        e[1] = ref_modexp(c, E_B);
        e[2] = ref_modexp(c, E_C);
        sb_q.push_back(e);
    endtask

    task automatic check_idle(input string tag);
        for (int k = 0; k < 3; k++) begin
            check({tag, "_state"}, 16'(st[k]), 16'd0);
            check({tag, "_sub"}, 16'(sub[k]), 16'd0);
            check({tag, "_outp"}, 16'(outp[k]), 16'd0);
        end
    endtask

    task automatic load_job(input logic [15:0] c);
        logic [15:0] cv;
        cv = c;
        push_expect(c);
        startInput = 1'b1;
        tick();
        check("load_enter", 16'(st[0]), 16'd1);
        startInput = 1'b0;
        for (int w = 0; w < int'(NW); w++) begin
            inp = cv[w*DW +: DW];
            tick();
        end
        inp = '0;
        check("wait_enter", 16'(st[0]), 16'd2);
    endtask

    task automatic compute_job();
        int cyc;
        startCompute = 1'b1;
        tick();
        check("compute_enter", 16'(st[0]), 16'd3);
        startCompute = 1'b0;
        cyc = 0;
        while (!(st[0] == 5'd4 && st[1] == 5'd4 && st[2] == 5'd4) && cyc < int'(DONE_BOUND)) begin
            tick();
            cyc++;
        end
        check("done_in_bound", 16'(cyc < int'(DONE_BOUND)), 16'd1);
        for (int k = 0; k < 3; k++) begin
            check("done_sub", 16'(sub[k]), 16'd0);
            check("done_outp", 16'(outp[k]), 16'd0);
        end
    endtask

    // getResult stays high through the whole readout and one cycle beyond it.
    task automatic readout_job();
        exp_t e;
        e = sb_q.pop_front();
        getResult = 1'b1;
        for (int w = 0; w < int'(NW); w++) begin
            tick();
            for (int k = 0; k < 3; k++) begin
                check("out_state", 16'(st[k]), 16'd5);
                check("out_word", 16'(outp[k]), 16'(e[k][w*DW +: DW]));
            end
        end
        tick();
        check_idle("out_end");
        tick();
        check("idle_hold", 16'(st[0]), 16'd0);
        getResult = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        startInput   = 1'b0;
        startCompute = 1'b0;
        getResult    = 1'b0;
        inp          = '0;
        tick();
        tick();
        check_idle("reset");
        reset = 1'b0;
        tick();

        // Encrypt 65 with E=17 (and same c through the other keys).
        load_job(16'd65);
        compute_job();
        readout_job();

        // Decrypt 2790 with E=2753 back to 65.
        load_job(16'd2790);
        compute_job();
        readout_job();

        // c >= N is reduced first.
        load_job(16'd3298);
        compute_job();
        readout_job();

        // c == N gives zero for nonzero exponents.
        load_job(16'd3233);
        compute_job();
        readout_job();

        // Reset mid-compute aborts; the queued expectation is discarded.
        load_job(16'd65);
        startCompute = 1'b1;
        tick();
        startCompute = 1'b0;
        repeat (40) tick();
        check("abort_busy", 16'(st[0]), 16'd3);
        reset = 1'b1;
        tick();
        check_idle("abort");
        reset = 1'b0;
        void'(sb_q.pop_back());
        tick();
        load_job(16'd65);
        compute_job();
        readout_job();

        // Protocol: startCompute in LOAD, extra words / startInput / getResult in WAIT.
        push_expect(16'h04D2);
        startInput = 1'b1;
        tick();
        startInput   = 1'b0;
        startCompute = 1'b1;
        inp          = 8'hD2;
        tick();
        check("load_ignore_compute", 16'(st[0]), 16'd1);
        startCompute = 1'b0;
        inp          = 8'h04;
        tick();
        check("proto_wait", 16'(st[0]), 16'd2);
        inp = 8'hFF;
        tick();
        inp        = 8'h5A;
        startInput = 1'b1;
        getResult  = 1'b1;
        tick();
        check("wait_ignore", 16'(st[0]), 16'd2);
        check("wait_outp", 16'(outp[0]), 16'd0);
        startInput = 1'b0;
        getResult  = 1'b0;
        inp        = '0;
        compute_job();
        readout_job();

        check("sb_empty", 16'(sb_q.size()), 16'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
